// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared opcode, ALUOp and control-bundle definitions for the RV32I ID stage
//
// Purpose: constants and the control bundle carried from ID into EX.
// Contents:
//   OP_*        7-bit major opcodes of the supported instruction classes
//   ALUOP_*     2-bit ALUOp encodings consumed by the EX-stage ALU control unit
//   ctrl_t      registered control bundle (valid, ALUOp, Funct, enables, illegal)
//   BUBBLE      all-zero bundle used for reset, flush and load-use bubbles
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [1:0] alu_op;
        logic [3:0] funct;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/main_decoder.sv
// rtl/main_decoder.sv - combinational RV32I main control decoder
//
// Purpose: maps opcode/funct fields to the control bundle and reports whether
// the instruction reads rs2. The valid bit of the bundle is left at 0; the
// ID/EX wrapper owns it.
// Ports:
//   i_opcode    instruction bits [6:0]
//   i_funct3    instruction bits [14:12]
//   i_bit30     instruction bit 30 (add/sub, srl/sra select for R-type)
//   i_rd_zero   destination field is x0
//   o_ctrl      decoded control bundle
//   o_uses_rs2  instruction reads rs2 (R-type, store, branch)
module main_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_bit30,
    input  logic       i_rd_zero,
    output ctrl_t      o_ctrl,
    output logic       o_uses_rs2
);

    always_comb begin
        o_ctrl     = BUBBLE;
        o_uses_rs2 = 1'b0;
        case (i_opcode)
            OP_R: begin
                o_ctrl.alu_op    = ALUOP_R;
                o_ctrl.funct     = {i_bit30, i_funct3};
                o_ctrl.reg_write = 1'b1;
                o_uses_rs2       = 1'b1;
            end
            OP_I: begin
                // bit 30 is part of the immediate here (srai), so it stays out of Funct
                o_ctrl.alu_op    = ALUOP_MEM;
                o_ctrl.funct     = {1'b0, i_funct3};
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            OP_LOAD: begin
                // Funct stays 0000 so the ALU always adds for address generation
                o_ctrl.alu_op     = ALUOP_MEM;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
            end
            OP_STORE: begin
                // sh/sb funct3 would otherwise look like a shift to the ALU control
                o_ctrl.alu_op    = ALUOP_MEM;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_uses_rs2       = 1'b1;
            end
            OP_BRANCH: begin
                o_ctrl.alu_op = ALUOP_BR;
                o_ctrl.funct  = {1'b0, i_funct3};
                o_ctrl.branch = 1'b1;
                o_uses_rs2    = 1'b1;
            end
            default: begin
                o_ctrl.illegal = 1'b1;
            end
        endcase

        // writes to x0 are architecturally discarded; dropping them here also
        // keeps forwarding logic downstream from matching on rd == 0
        if (i_rd_zero) begin
            o_ctrl.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_control_pipe.sv
// rtl/id_ex_control_pipe.sv - ID-stage decode, load-use hazard detection and ID/EX control register
//
// Purpose: decodes the IF/ID instruction, detects load-use hazards against the
// instruction in EX, and registers the control field into EX with bubble
// insertion on reset, flush and hazard.
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   id_valid, id_instr    IF/ID contents
//   stall_in              hold the ID/EX register
//   flush_ex              branch taken in EX; the incoming instruction is killed
//   hazard_stall          combinational load-use stall for PC and IF/ID
//   ex_valid .. ex_illegal  registered ID/EX control field and register indices
module id_ex_control_pipe
    import rv_ctrl_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [INSTR_W-1:0]    id_instr,
    input  logic                  stall_in,
    input  logic                  flush_ex,
    output logic                  hazard_stall,
    output logic                  ex_valid,
    output logic [1:0]            ex_ALUOp,
    output logic [3:0]            ex_Funct,
    output logic                  ex_ALUSrc,
    output logic                  ex_MemRead,
    output logic                  ex_MemWrite,
    output logic                  ex_MemtoReg,
    output logic                  ex_RegWrite,
    output logic                  ex_Branch,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic                  ex_illegal
);

    ctrl_t                 w_dec;
    ctrl_t                 w_next;
    logic                  w_uses_rs2;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [REG_ADDR_W-1:0] w_rs1;
    logic [REG_ADDR_W-1:0] w_rs2;
    logic                  w_unused;

    ctrl_t                 r_ctrl;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [REG_ADDR_W-1:0] r_rs1;
    logic [REG_ADDR_W-1:0] r_rs2;

    assign w_rd     = id_instr[7  +: REG_ADDR_W];
    assign w_rs1    = id_instr[15 +: REG_ADDR_W];
    assign w_rs2    = id_instr[20 +: REG_ADDR_W];
    // immediate-only bits play no part in control decode
    assign w_unused = ^{id_instr[INSTR_W-1:31], id_instr[29:25]};

    main_decoder u_main_decoder (
        .i_opcode   (id_instr[6:0]),
        .i_funct3   (id_instr[14:12]),
        .i_bit30    (id_instr[30]),
        .i_rd_zero  (w_rd == '0),
        .o_ctrl     (w_dec),
        .o_uses_rs2 (w_uses_rs2)
    );

    always_comb begin
        w_next       = w_dec;
        w_next.valid = 1'b1;
    end

    // rs1 is compared unconditionally: every supported opcode reads it, and a
    // spurious stall on an illegal opcode costs one cycle and nothing else.
    assign hazard_stall = id_valid & r_ctrl.valid & r_ctrl.mem_read & (r_rd != '0) &
                          ((r_rd == w_rs1) | (w_uses_rs2 & (r_rd == w_rs2)));

    always_ff @(posedge clk) begin
        if (reset || flush_ex) begin
            r_ctrl <= BUBBLE;
            r_rd   <= '0;
            r_rs1  <= '0;
            r_rs2  <= '0;
        end else if (stall_in) begin
            r_ctrl <= r_ctrl;
            r_rd   <= r_rd;
            r_rs1  <= r_rs1;
            r_rs2  <= r_rs2;
        end else if (hazard_stall || !id_valid) begin
            // the bubble clears mem_read, so a load-use stall lasts one cycle
            r_ctrl <= BUBBLE;
            r_rd   <= '0;
            r_rs1  <= '0;
            r_rs2  <= '0;
        end else begin
            r_ctrl <= w_next;
            r_rd   <= w_rd;
            r_rs1  <= w_rs1;
            r_rs2  <= w_rs2;
        end
    end

    assign ex_valid    = r_ctrl.valid;
    assign ex_ALUOp    = r_ctrl.alu_op;
    assign ex_Funct    = r_ctrl.funct;
    assign ex_ALUSrc   = r_ctrl.alu_src;
    assign ex_MemRead  = r_ctrl.mem_read;
    assign ex_MemWrite = r_ctrl.mem_write;
    assign ex_MemtoReg = r_ctrl.mem_to_reg;
    assign ex_RegWrite = r_ctrl.reg_write;
    assign ex_Branch   = r_ctrl.branch;
    assign ex_illegal  = r_ctrl.illegal;
    assign ex_rd       = r_rd;
    assign ex_rs1      = r_rs1;
    assign ex_rs2      = r_rs2;

endmodule

// File: tb/tb_id_ex_control_pipe.sv
// tb/tb_id_ex_control_pipe.sv - self-checking bench for id_ex_control_pipe
module tb_id_ex_control_pipe;

    // flags order: {ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, Branch, illegal}
    typedef struct packed {
        logic       v;
        logic [1:0] aluop;
        logic [3:0] funct;
        logic [6:0] flags;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        valid;
        exp_t        e;
    } vec_t;

    localparam exp_t E_BUB = '0;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        stall_in;
    logic        flush_ex;
    logic        hazard_stall;
    logic        ex_valid;
    logic [1:0]  ex_ALUOp;
    logic [3:0]  ex_Funct;
    logic        ex_ALUSrc;
    logic        ex_MemRead;
    logic        ex_MemWrite;
    logic        ex_MemtoReg;
    logic        ex_RegWrite;
    logic        ex_Branch;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic        ex_illegal;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t vecs[11];

    id_ex_control_pipe #(.INSTR_W(32), .REG_ADDR_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .stall_in     (stall_in),
        .flush_ex     (flush_ex),
        .hazard_stall (hazard_stall),
        .ex_valid     (ex_valid),
        .ex_ALUOp     (ex_ALUOp),
        .ex_Funct     (ex_Funct),
        .ex_ALUSrc    (ex_ALUSrc),
        .ex_MemRead   (ex_MemRead),
        .ex_MemWrite  (ex_MemWrite),
        .ex_MemtoReg  (ex_MemtoReg),
        .ex_RegWrite  (ex_RegWrite),
        .ex_Branch    (ex_Branch),
        .ex_rd        (ex_rd),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_illegal   (ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr);
        @(negedge clk);
        id_valid = v;
        id_instr = instr;
    endtask

    // advance one edge and compare EX against the oldest scoreboard entry
    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, " ex_valid"}, {31'd0, ex_valid}, {31'd0, e.v});
            chk({tag, " ex_ALUOp"}, {30'd0, ex_ALUOp}, {30'd0, e.aluop});
            chk({tag, " ex_Funct"}, {28'd0, ex_Funct}, {28'd0, e.funct});
            chk({tag, " flags"},
                {25'd0, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_RegWrite, ex_Branch, ex_illegal},
                {25'd0, e.flags});
            chk({tag, " ex_rd"},  {27'd0, ex_rd},  {27'd0, e.rd});
            chk({tag, " ex_rs1"}, {27'd0, ex_rs1}, {27'd0, e.rs1});
            chk({tag, " ex_rs2"}, {27'd0, ex_rs2}, {27'd0, e.rs2});
        end
    endtask

    task automatic chk_hazard(input string tag, input logic exp);
        #1;
        chk({tag, " hazard_stall"}, {31'd0, hazard_stall}, {31'd0, exp});
    endtask

    localparam exp_t E_LW5     = '{1'b1, 2'b00, 4'b0000, 7'b1101100, 5'd5, 5'd1, 5'd0};
    localparam exp_t E_ADD_DEP = '{1'b1, 2'b10, 4'b0000, 7'b0000100, 5'd6, 5'd5, 5'd7};
    localparam exp_t E_SW_DEP  = '{1'b1, 2'b00, 4'b0000, 7'b1010000, 5'd0, 5'd1, 5'd5};
    localparam exp_t E_BAD     = '{1'b1, 2'b00, 4'b0000, 7'b0000001, 5'd0, 5'd0, 5'd0};

    initial begin
        vecs[0]  = '{32'h002081B3, 1'b1, '{1'b1, 2'b10, 4'b0000, 7'b0000100, 5'd3, 5'd1, 5'd2}}; // add x3,x1,x2
        vecs[1]  = '{32'h402081B3, 1'b1, '{1'b1, 2'b10, 4'b1000, 7'b0000100, 5'd3, 5'd1, 5'd2}}; // sub
        vecs[2]  = '{32'h00209123, 1'b1, '{1'b1, 2'b00, 4'b0000, 7'b1010000, 5'd2, 5'd1, 5'd2}}; // sh x2,2(x1)
        vecs[3]  = '{32'h0000A283, 1'b1, '{1'b1, 2'b00, 4'b0000, 7'b1101100, 5'd5, 5'd1, 5'd0}}; // lw x5,0(x1)
        vecs[4]  = '{32'h00510213, 1'b1, '{1'b1, 2'b00, 4'b0000, 7'b1000100, 5'd4, 5'd2, 5'd5}}; // addi x4,x2,5
        vecs[5]  = '{32'h00209463, 1'b1, '{1'b1, 2'b01, 4'b0001, 7'b0000010, 5'd8, 5'd1, 5'd2}}; // bne x1,x2
        vecs[6]  = '{32'h00208033, 1'b1, '{1'b1, 2'b10, 4'b0000, 7'b0000000, 5'd0, 5'd1, 5'd2}}; // add x0,x1,x2
        vecs[7]  = '{32'h0000007F, 1'b1, '{1'b1, 2'b00, 4'b0000, 7'b0000001, 5'd0, 5'd0, 5'd0}}; // bad opcode
        vecs[8]  = '{32'h4020D193, 1'b1, '{1'b1, 2'b00, 4'b0101, 7'b1000100, 5'd3, 5'd1, 5'd2}}; // srai x3,x1,2
        vecs[9]  = '{32'h4020D1B3, 1'b1, '{1'b1, 2'b10, 4'b1101, 7'b0000100, 5'd3, 5'd1, 5'd2}}; // sra x3,x1,x2
        vecs[10] = '{32'h00728333, 1'b0, E_BUB};                                                // not valid

        reset    = 1'b1;
        id_valid = 1'b0;
        id_instr = 32'd0;
        stall_in = 1'b0;
        flush_ex = 1'b0;

        // reset state
        @(posedge clk);
        sb.push_back(E_BUB);
        step("reset");
        chk("reset hazard_stall", {31'd0, hazard_stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // table vectors; none of them forms a load-use pair (addi after lw does
        // not read rs2 even though its rs2 field equals the load's rd)
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].valid, vecs[i].instr);
            chk_hazard($sformatf("vec%0d", i), 1'b0);
            sb.push_back(vecs[i].e);
            step($sformatf("vec%0d", i));
        end

        // load-use on rs1: one stall cycle, one bubble, then the add
        drive(1'b1, 32'h0000A283);
        sb.push_back(E_LW5);
        step("lu_lw");
        drive(1'b1, 32'h00728333);
        chk_hazard("lu_stall", 1'b1);
        sb.push_back(E_BUB);
        step("lu_bubble");
        @(negedge clk);
        chk_hazard("lu_release", 1'b0);
        sb.push_back(E_ADD_DEP);
        step("lu_add");

        // load-use on rs2 of a store
        drive(1'b1, 32'h0000A283);
        sb.push_back(E_LW5);
        step("lus_lw");
        drive(1'b1, 32'h0050A023);
        chk_hazard("lus_stall", 1'b1);
        sb.push_back(E_BUB);
        step("lus_bubble");
        @(negedge clk);
        chk_hazard("lus_release", 1'b0);
        sb.push_back(E_SW_DEP);
        step("lus_sw");

        // flush, then flush with stall_in
        drive(1'b1, 32'h002081B3);
        flush_ex = 1'b1;
        sb.push_back(E_BUB);
        step("flush");
        @(negedge clk);
        stall_in = 1'b1;
        sb.push_back(E_BUB);
        step("flush_stall");
        @(negedge clk);
        flush_ex = 1'b0;
        stall_in = 1'b0;

        // flush coinciding with a load-use hazard
        drive(1'b1, 32'h0000A283);
        sb.push_back(E_LW5);
        step("fh_lw");
        drive(1'b1, 32'h00728333);
        flush_ex = 1'b1;
        chk_hazard("fh_stall", 1'b1);
        sb.push_back(E_BUB);
        step("fh_bubble");
        @(negedge clk);
        flush_ex = 1'b0;

        // illegal opcode held by three stall cycles
        drive(1'b1, 32'h0000007F);
        sb.push_back(E_BAD);
        step("ill");
        drive(1'b1, 32'h002081B3);
        stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(E_BAD);
            step($sformatf("ill_hold%0d", k));
        end
        @(negedge clk);
        stall_in = 1'b0;

        // reset while a load-use stall is active
        drive(1'b1, 32'h0000A283);
        sb.push_back(E_LW5);
        step("rs_lw");
        drive(1'b1, 32'h00728333);
        chk_hazard("rs_stall", 1'b1);
        reset = 1'b1;
        sb.push_back(E_BUB);
        step("rs_bubble");
        chk("rs hazard_drop", {31'd0, hazard_stall}, 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        id_valid = 1'b0;

        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_control_pipe.md
Name: id_ex_control_pipe

Overview:
- ID-stage main control decoder plus the ID/EX pipeline register for the control field of the pipelined RV32I core.
- It is the producer side of the ALUOp/Funct interface. It decodes the instruction, generates ALUOp[1:0], Funct[3:0] and the datapath enables, then registers them into EX, where the ALU control unit turns them into an ALU Operation.
- It also performs load-use hazard detection and inserts bubbles on hazard or branch flush.

Parameters:
- INSTR_W, 32, instruction width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  IF/ID holds a valid instruction.
- id_instr  in  INSTR_W  instruction held in IF/ID.
- stall_in  in  1  external stall; holds the ID/EX register.
- flush_ex  in  1  branch taken in EX; kills the instruction entering EX.
- hazard_stall  out  1  combinational; freezes PC and IF/ID for the current cycle.
- ex_valid  out  1  registered; EX holds a real instruction.
- ex_ALUOp  out  2  registered: 00 = load/store/I-ALU, 01 = branch, 10 = R-type.
- ex_Funct  out  4  registered: {instr[30], funct3} for R-type; funct3 alone otherwise.
- ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_RegWrite, ex_Branch  out  1 each  registered control signals.
- ex_rd, ex_rs1, ex_rs2  out  REG_ADDR_W each  registered register indices.
- ex_illegal  out  1  registered; the opcode is unsupported.

Behaviour:
- Supported opcodes:
  - R-type 0110011: ALUOp 10; Funct {i[30], i[14:12]}; RegWrite = 1.
  - I-ALU 0010011: ALUOp 00; Funct {0, i[14:12]}; ALUSrc = 1; RegWrite = 1.
  - Load 0000011: ALUOp 00; Funct forced to 0000; ALUSrc, MemRead, MemtoReg, RegWrite = 1.
  - Store 0100011: ALUOp 00; Funct forced to 0000; ALUSrc, MemWrite = 1.
  - Branch 1100011: ALUOp 01; Funct {0, i[14:12]}; Branch = 1.
- Funct is forced to 0000 for loads and stores so that sh/sb funct3 never decodes as a shift.
- Any other opcode: all enables 0, ALUOp 00, Funct 0000, ex_illegal = 1.
- RegWrite is forced to 0 when rd == 0.
- rs1 is used by every supported opcode. rs2 is used only by R-type, store and branch.
- hazard_stall = id_valid & ex_valid & ex_MemRead & (ex_rd != 0) & ((ex_rd == rs1) | (uses_rs2 & ex_rd == rs2)).
- A bubble is: ex_valid = 0, all enables 0, ex_illegal = 0, ALUOp 00, Funct 0000, indices 0.
- ID/EX update priority on each edge:
  1. reset: bubble.
  2. flush_ex: bubble.
  3. stall_in: hold the current contents.
  4. hazard_stall: bubble.
  5. Otherwise capture the decode of id_instr, with ex_valid = id_valid. When id_valid = 0, all enables are 0.
- Load-use stall lasts exactly 1 cycle, because the bubble clears ex_MemRead on the next cycle. The dependent instruction enters EX two cycles after the load.
- Reset values: every registered output is 0. hazard_stall is 0 because it depends only on registered ex_* signals, which are 0 after reset.
- Simultaneous events:
  - flush_ex with hazard_stall: the result is a bubble. hazard_stall still asserts for that cycle; the IF/ID refill is handled by the fetch logic.
  - stall_in with flush_ex: flush wins.
- Latency: decode to ex_* outputs is 1 cycle.
- Reset asserted mid-stall: bubble on the next edge, and hazard_stall drops in the same cycle.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH);
  - ALUOp constants (ALUOP_MEM = 00, ALUOP_BR = 01, ALUOP_R = 10);
  - a control-bundle struct and a BUBBLE constant.
- One sub-module: main_decoder, purely combinational, mapping opcode/funct to the control bundle plus uses_rs2. The wrapper holds the hazard logic and the ID/EX register.

Test Plan:
- Reset, then id_instr = 0x002081B3 (add x3,x1,x2) with id_valid = 1 -> next cycle: ALUOp 10, Funct 0000, RegWrite 1, rd 3, ex_valid 1.
- id_instr = 0x402081B3 (sub) -> Funct 1000. id_instr = 0x00209123 (sh x2,2(x1)) -> ALUOp 00, Funct 0000, MemWrite 1, ALUSrc 1, RegWrite 0.
- 0x0000A283 (lw x5,0(x1)) followed by 0x00728333 (add x6,x5,x7) -> hazard_stall = 1 for exactly 1 cycle; one bubble in EX; add reaches EX one cycle later with rs1 = 5, rs2 = 7.
- beq in EX with flush_ex = 1 while 0x002081B3 is in ID -> next cycle ex_valid 0 and all enables 0. With stall_in and flush_ex both 1 -> still a bubble.
- id_instr = 0x0000007F (bad opcode) -> ex_illegal 1, all enables 0. stall_in = 1 for 3 cycles -> ex_* outputs unchanged.
- reset pulsed while a lw is in EX and hazard_stall = 1 -> next cycle all outputs 0 and hazard_stall 0.
